instr_sequencer: RTL and testbench

Upstream stage that drives the register bank and ALUX from the 80-bit instruction words produced by `variables`. It steps an index through the instruction table and writes each operand into the register bank. It then starts the ALU and waits for `done` under a per-instruction cycle budget. It captures the result, which becomes the next instruction's operand when chaining is compiled in. This replaces the hand-written bench task with synthesizable control.

---
 rtl/seq_pkg.sv | 50 +++++
 rtl/instr_sequencer_if.sv | 39 +++
 rtl/seq_timeout_cnt.sv | 28 ++
 rtl/instr_sequencer.sv | 176 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// instruction-word field positions and the latched control-field layout.
package seq_pkg;

    localparam int unsigned INSTR_W   = 80;

    localparam int unsigned OP_HI     = 79;
    localparam int unsigned OP_LO     = 16;
    localparam int unsigned OPR_HI    = 15;
    localparam int unsigned OPR_LO    = 12;
    localparam int unsigned MAXC_HI   = 11;
    localparam int unsigned MAXC_LO   = 6;
    localparam int unsigned ENDW_HI   = 5;
    localparam int unsigned ENDW_LO   = 4;
    localparam int unsigned ENRA_BIT  = 3;
    localparam int unsigned ENRB_BIT  = 2;
    localparam int unsigned CNSTA_BIT = 1;
    localparam int unsigned CNSTB_BIT = 0;

    localparam int unsigned OPND_W    = OP_HI - OP_LO + 1;
    localparam int unsigned OPR_W     = OPR_HI - OPR_LO + 1;
    localparam int unsigned MAXC_W    = MAXC_HI - MAXC_LO + 1;
    localparam int unsigned ENDW_W    = ENDW_HI - ENDW_LO + 1;

    localparam int unsigned STATE_W   = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] ST_WRITE = 3'd2;
    localparam logic [STATE_W-1:0] ST_EXEC  = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT  = 3'd4;
    localparam logic [STATE_W-1:0] ST_STORE = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;

    // Non-operand fields of an instruction word, held for one instruction
    typedef struct packed {
        logic [OPR_W-1:0]  opr;
        logic [MAXC_W-1:0] maxclock;
        logic [ENDW_W-1:0] endwreg;
        logic              enrregA;
        logic              enrregB;
        logic              cnstA;
        logic              cnstB;
    } instr_ctrl_t;

    function automatic logic state_busy(input logic [STATE_W-1:0] st);
        return !(st == ST_IDLE || st == ST_DONE);
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bus between the sequencer and the instruction table / register bank / ALU.
// master = sequencer side, slave = datapath side.
interface instr_sequencer_if
    import seq_pkg::*;
#(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned DATA_W = 64
) ();

    logic [IDX_W-1:0]   instr_idx;
    logic [INSTR_W-1:0] instr_word;
    logic               regwen;
    logic [IDX_W-1:0]   selwreg;
    logic [ENDW_W-1:0]  endwreg;
    logic [DATA_W-1:0]  wdata;
    logic [IDX_W-1:0]   seloutA;
    logic [IDX_W-1:0]   seloutB;
    logic               enrregA;
    logic               enrregB;
    logic               cnstA;
    logic               cnstB;
    logic [OPR_W-1:0]   opr;
    logic               start;
    logic               done;
    logic [DATA_W-1:0]  result;

    modport master (
        output instr_idx, regwen, selwreg, endwreg, wdata, seloutA, seloutB,
               enrregA, enrregB, cnstA, cnstB, opr, start,
        input  instr_word, done, result
    );

    modport slave (
        input  instr_idx, regwen, selwreg, endwreg, wdata, seloutA, seloutB,
               enrregA, enrregB, cnstA, cnstB, opr, start,
        output instr_word, done, result
    );

endinterface

// File: rtl/seq_timeout_cnt.sv
// Per-instruction cycle budget counter; expired flags the last allowed
// WAIT cycle. A zero limit never expires.
module seq_timeout_cnt #(
    parameter int unsigned W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expired = (limit != '0) && (cnt_q == limit - W'(1));

endmodule

// File: rtl/instr_sequencer.sv
// Steps through the instruction table, writes each operand to the register
// bank, runs the ALU under a cycle budget and captures its result.
// Optional SEQ_CHAIN_EN: operands after entry 0 come from the previous result.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NUM_INSTR = 16,
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned DATA_W    = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    instr_sequencer_if.master bus,
    output logic [DATA_W-1:0] last_result,
    output logic              busy,
    output logic              finished,
    output logic              timeout
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INSTR - 1);

    logic [STATE_W-1:0] state_q,    state_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    instr_ctrl_t        ctrl_q,     ctrl_d;
    logic [DATA_W-1:0]  operand_q,  operand_d;
    logic [DATA_W-1:0]  res_cap_q,  res_cap_d;
    logic [DATA_W-1:0]  last_q,     last_d;
    logic               timeout_q,  timeout_d;
    logic               regwen_q,   regwen_d;
    logic               start_q,    start_d;
    logic               busy_q,     busy_d;
    logic               finished_q, finished_d;

    logic               cnt_clr;
    logic               cnt_en;
    logic               expired;
    logic [DATA_W-1:0]  word_operand;

    assign word_operand = DATA_W'(bus.instr_word[OP_HI:OP_LO]);

    seq_timeout_cnt #(.W(MAXC_W)) u_timeout_cnt (
        .clock   (clock),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (ctrl_q.maxclock),
        .expired (expired)
    );

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            ctrl_q     <= '0;
            operand_q  <= '0;
            res_cap_q  <= '0;
            last_q     <= '0;
            timeout_q  <= 1'b0;
            regwen_q   <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ctrl_q     <= ctrl_d;
            operand_q  <= operand_d;
            res_cap_q  <= res_cap_d;
            last_q     <= last_d;
            timeout_q  <= timeout_d;
            regwen_q   <= regwen_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            finished_q <= finished_d;
        end
    end

    // Next state; pulse outputs are decoded from the state being entered
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ctrl_d    = ctrl_q;
        operand_d = operand_q;
        res_cap_d = res_cap_q;
        last_d    = last_q;
        timeout_d = timeout_q;
        regwen_d  = 1'b0;
        start_d   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_d   = ST_FETCH;
                    idx_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_FETCH: begin
                ctrl_d = '{
                    opr:      bus.instr_word[OPR_HI:OPR_LO],
                    maxclock: bus.instr_word[MAXC_HI:MAXC_LO],
                    endwreg:  bus.instr_word[ENDW_HI:ENDW_LO],
                    enrregA:  bus.instr_word[ENRA_BIT],
                    enrregB:  bus.instr_word[ENRB_BIT],
                    cnstA:    bus.instr_word[CNSTA_BIT],
                    cnstB:    bus.instr_word[CNSTB_BIT]
                };
`ifdef SEQ_CHAIN_EN
                operand_d = (idx_q == '0) ? word_operand : last_q;
`else
                operand_d = word_operand;
`endif
                state_d  = ST_WRITE;
                regwen_d = 1'b1;
            end
            ST_WRITE: begin
                state_d = ST_EXEC;
                start_d = 1'b1;
            end
            ST_EXEC: begin
                cnt_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                // done beats an expiring budget in the same cycle
                if (bus.done) begin
                    res_cap_d = bus.result;
                    state_d   = ST_STORE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_STORE: begin
                last_d = res_cap_q;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = state_busy(state_d);
        finished_d = (state_d == ST_DONE);
    end

    assign bus.instr_idx = idx_q;
    assign bus.selwreg   = idx_q;
    assign bus.seloutA   = idx_q;
    assign bus.seloutB   = idx_q;
    assign bus.regwen    = regwen_q;
    assign bus.wdata     = operand_q;
    assign bus.endwreg   = ctrl_q.endwreg;
    assign bus.enrregA   = ctrl_q.enrregA;
    assign bus.enrregB   = ctrl_q.enrregB;
    assign bus.cnstA     = ctrl_q.cnstA;
    assign bus.cnstB     = ctrl_q.cnstB;
    assign bus.opr       = ctrl_q.opr;
    assign bus.start     = start_q;

    assign last_result = last_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a table-level reference model queues
// expected writes, starts and final status; a monitor pops them as they occur.
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned DW = 64;
`ifdef SEQ_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif
    localparam logic [79:0] W1 = {64'h1234, 4'h3, 6'd0, 2'b10, 4'b1010};

    logic clock = 1'b0;
    logic reset, go, go1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    instr_sequencer_if #(.IDX_W(IW), .DATA_W(DW)) bus ();
    instr_sequencer_if #(.IDX_W(IW), .DATA_W(DW)) bus1 ();
    logic [DW-1:0] last_result, lr1;
    logic busy, finished, timeout, busy1, fin1, to1;

    instr_sequencer #(.NUM_INSTR(N), .IDX_W(IW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .go(go), .bus(bus),
        .last_result(last_result), .busy(busy), .finished(finished), .timeout(timeout)
    );

    instr_sequencer #(.NUM_INSTR(1), .IDX_W(IW), .DATA_W(DW)) dut1 (
        .clock(clock), .reset(reset), .go(go1), .bus(bus1),
        .last_result(lr1), .busy(busy1), .finished(fin1), .timeout(to1)
    );

    logic [79:0] tbl [N];
    int          dly [N];
    assign bus.instr_word  = tbl[bus.instr_idx];
    assign bus1.instr_word = W1;

    typedef struct { logic [IW-1:0] sel; logic [63:0] data; logic [1:0] endw; logic [3:0] flags; } wr_t;
    typedef struct { logic [3:0] opr; logic [IW-1:0] sel; } st_t;
    typedef struct { logic to; logic [63:0] last; int cyc; } fin_t;
    wr_t  wr_q  [$];
    st_t  st_q  [$];
    fin_t fin_q [$];

    int tests = 0;
    int fails = 0;
    logic [63:0] m_last;
    logic [63:0] seen_w1;

    function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [3:0] op);
        return a + 64'(op) + 64'd1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic miss(input string nm);
        tests++;
        fails++;
        $display("FAIL unexpected_%s: pulse seen with nothing expected (t=%0t)", nm, $time);
    endtask

    // Reference: walk the table, summing per-instruction cycle costs
    task automatic push_expect(input int s);
        logic [63:0] prev, op;
        logic [79:0] wd;
        int t, mc;
        logic to;
        prev = m_last;
        t = 0;
        to = 1'b0;
        for (int i = 0; i < N; i++) begin
            wd = tbl[i];
            op = (CHAIN && i > 0) ? prev : wd[79:16];
            wr_q.push_back('{IW'(i), op, wd[5:4], wd[3:0]});
            st_q.push_back('{wd[15:12], IW'(i)});
            mc = int'(wd[11:6]);
            if (mc != 0 && (dly[i] == 0 || dly[i] > mc)) begin
                to = 1'b1;
                t += 3 + mc;
                break;
            end
            prev = alu_f(op, wd[15:12]);
            t += 4 + dly[i];
        end
        m_last = prev;
        fin_q.push_back('{to, prev, s + t});
    endtask

    task automatic set_entry(input int i, input int mc, input int d);
        tbl[i] = 80'({$urandom, $urandom, $urandom});
        tbl[i][11:6] = 6'(mc);
        dly[i] = d;
    endtask

    task automatic rand_table();
        int mc, d;
        for (int i = 0; i < N; i++) begin
            mc = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 12));
            d  = int'($urandom_range(1, 8));
            if (mc != 0 && $urandom_range(0, 11) == 0) d = 0;
            set_entry(i, mc, d);
        end
    endtask

    task automatic run_seq();
        int k;
        @(posedge clock); #2;
        go = 1'b1;
        push_expect(cyc + 1);
        @(posedge clock); #2;
        go = 1'b0;
        chk("go_clears_finished", 64'(finished), 64'd0);
        chk("go_sets_busy", 64'(busy), 64'd1);
        k = 0;
        while (fin_q.size() != 0 && k < 1000) begin
            @(posedge clock);
            k++;
        end
        #2;
        chk("run_completed", 64'(fin_q.size()), 64'd0);
        chk("writes_left", 64'(wr_q.size() - (timeout ? wr_q.size() : 0)), 64'd0);
        chk("starts_left", 64'(st_q.size() - (timeout ? st_q.size() : 0)), 64'd0);
        wr_q.delete();
        st_q.delete();
    endtask

    // ALU model: done on the d-th WAIT cycle (d=0: never), result from written operand
    initial begin : alu
        logic [63:0] a_in;
        logic [3:0]  op;
        int c, d;
        bit pend;
        bus.done = 1'b0;
        bus.result = '0;
        a_in = '0; op = '0; c = 0; d = 0; pend = 1'b0;
        forever begin
            @(posedge clock); #1;
            bus.done = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                if (bus.regwen) a_in = bus.wdata;
                if (bus.start) begin
                    pend = 1'b1; c = 0; d = dly[bus.instr_idx]; op = bus.opr;
                end else if (pend) begin
                    c++;
                    if (d != 0 && c == d) begin
                        bus.done = 1'b1;
                        bus.result = alu_f(a_in, op);
                        pend = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : alu1
        int c;
        bit pend;
        bus1.done = 1'b0;
        bus1.result = '0;
        c = 0; pend = 1'b0;
        forever begin
            @(posedge clock); #1;
            bus1.done = 1'b0;
            if (reset) pend = 1'b0;
            else if (bus1.start) begin pend = 1'b1; c = 0; end
            else if (pend) begin
                c++;
                if (c == 3) begin bus1.done = 1'b1; bus1.result = 64'hABCD; pend = 1'b0; end
            end
        end
    end

    initial begin : mon
        wr_t w;
        st_t s;
        fin_t f;
        logic fin_prev;
        fin_prev = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (reset) begin
                fin_prev = 1'b0;
            end else begin
                if (bus.regwen) begin
                    if (wr_q.size() == 0) miss("regwen");
                    else begin
                        w = wr_q.pop_front();
                        chk("wr_selwreg", 64'(bus.selwreg), 64'(w.sel));
                        chk("wr_wdata", bus.wdata, w.data);
                        chk("wr_endwreg", 64'(bus.endwreg), 64'(w.endw));
                        chk("wr_flags", 64'({bus.enrregA, bus.enrregB, bus.cnstA, bus.cnstB}), 64'(w.flags));
                        if (bus.selwreg == IW'(1)) seen_w1 = bus.wdata;
                    end
                end
                if (bus.start) begin
                    if (st_q.size() == 0) miss("start");
                    else begin
                        s = st_q.pop_front();
                        chk("st_opr", 64'(bus.opr), 64'(s.opr));
                        chk("st_seloutA", 64'(bus.seloutA), 64'(s.sel));
                        chk("st_seloutB", 64'(bus.seloutB), 64'(s.sel));
                    end
                end
                if (finished && !fin_prev) begin
                    if (fin_q.size() == 0) miss("finished");
                    else begin
                        f = fin_q.pop_front();
                        chk("fin_timeout", 64'(timeout), 64'(f.to));
                        chk("fin_last_result", last_result, f.last);
                        chk("fin_cycle", 64'(cyc), 64'(f.cyc));
                    end
                end
                fin_prev = finished;
            end
        end
    end

    initial begin : main
        int k, s1, fc, nw, ns;
        logic [63:0] w1d, w1s;
        logic found;
        reset = 1'b1; go = 1'b0; go1 = 1'b0;
        m_last = '0; seen_w1 = '0;
        for (int i = 0; i < N; i++) begin tbl[i] = '0; dly[i] = 1; end
        repeat (3) @(posedge clock);
        #2;
        chk("rst_idx", 64'(bus.instr_idx), 64'd0);
        chk("rst_regwen", 64'(bus.regwen), 64'd0);
        chk("rst_start", 64'(bus.start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_finished", 64'(finished), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_last_result", last_result, 64'd0);
        reset = 1'b0;

        // Single-instruction table
        @(posedge clock); #2;
        go1 = 1'b1;
        @(posedge clock); #2;
        s1 = cyc; go1 = 1'b0;
        fc = -1; nw = 0; ns = 0; w1d = '1; w1s = '1;
        for (k = 0; k < 60; k++) begin
            @(posedge clock); #2;
            if (bus1.regwen) begin nw++; w1d = bus1.wdata; w1s = 64'(bus1.selwreg); end
            if (bus1.start) ns++;
            if (fin1) begin fc = cyc; break; end
        end
        chk("one_regwen_count", 64'(nw), 64'd1);
        chk("one_wdata", w1d, 64'h1234);
        chk("one_selwreg", w1s, 64'd0);
        chk("one_start_count", 64'(ns), 64'd1);
        chk("one_finish_latency", 64'(fc - s1), 64'd7);
        chk("one_last_result", lr1, 64'hABCD);
        chk("one_timeout", 64'(to1), 64'd0);

        // Full table, no budgets; entry 1 shows chaining
        for (int i = 0; i < N; i++) set_entry(i, 0, int'($urandom_range(1, 4)));
        tbl[0][79:16] = 64'h1; tbl[0][15:12] = 4'h0;
        tbl[1][79:16] = 64'hFF; tbl[1][15:12] = 4'h0;
        run_seq();
        chk("chain_idx1_wdata", seen_w1, CHAIN ? 64'h2 : 64'hFF);
        repeat (5) @(posedge clock);
        #2;
        chk("hold_finished", 64'(finished), 64'd1);
        chk("hold_idx", 64'(bus.instr_idx), 64'd15);
        chk("hold_busy", 64'(busy), 64'd0);

        // Budget expiry on entry 0
        set_entry(0, 5, 0);
        run_seq();
        chk("budget_timeout", 64'(timeout), 64'd1);

        // done on the last budgeted cycle wins
        for (int i = 0; i < N; i++) set_entry(i, 5, 5);
        run_seq();
        chk("tie_timeout", 64'(timeout), 64'd0);
        chk("tie_idx", 64'(bus.instr_idx), 64'd15);

        for (int r = 0; r < 8; r++) begin
            rand_table();
            run_seq();
        end

        // Reset while waiting on entry 3
        for (int i = 0; i < N; i++) set_entry(i, 0, int'($urandom_range(1, 4)));
        dly[3] = 30;
        @(posedge clock); #2;
        go = 1'b1;
        push_expect(cyc + 1);
        @(posedge clock); #2;
        go = 1'b0;
        found = 1'b0;
        for (k = 0; k < 400; k++) begin
            @(posedge clock); #2;
            if (bus.start && bus.instr_idx == IW'(3)) begin found = 1'b1; break; end
        end
        chk("mid_reach_idx3", 64'(found), 64'd1);
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rst_idx", 64'(bus.instr_idx), 64'd0);
        chk("mid_rst_regwen", 64'(bus.regwen), 64'd0);
        chk("mid_rst_start", 64'(bus.start), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_last_result", last_result, 64'd0);
        #1;
        reset = 1'b0;
        wr_q.delete(); st_q.delete(); fin_q.delete();
        m_last = '0;
        repeat (6) @(posedge clock);
        #2;
        chk("post_rst_idle", 64'(busy), 64'd0);

        rand_table();
        run_seq();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
